// File: rtl/xsim_arb_pkg.sv
// Shared types and header decode for the xsim portal source arbiter.
package xsim_arb_pkg;

   typedef logic [31:0] beat_t;

   typedef enum logic {IDLE, BODY} arb_state_t;

   localparam int HDR_LEN_MSB = 15;
   localparam int HDR_LEN_LSB = 0;

   // Message length in words (header included); a zero length still occupies the header beat.
   function automatic logic [15:0] hdr_len(beat_t b);
      logic [15:0] l;
      l = b[HDR_LEN_MSB:HDR_LEN_LSB];
      return (l == 16'd0) ? 16'd1 : l;
   endfunction

endpackage

// File: rtl/xsim_rr_picker.sv
// Rotating-priority encoder: first set req bit scanning last+1 .. last+N (mod N).
module xsim_rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          any,
   output logic [IW-1:0] idx
);

   // Scan from the farthest slot back to the nearest so the nearest valid requester wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[IW'((int'(last) + k) % N)]) begin
            any = 1'b1;
            idx = IW'((int'(last) + k) % N);
         end
      end
   end

endmodule

// File: rtl/xsim_portal_source_arb.sv
// Message-atomic round-robin arbiter feeding one xsim msgSource beat channel.
// A grant is held for every beat of a message; length comes from header[15:0].
// Optional: define XSIM_ARB_WATCHDOG_EN to build a mid-message stall watchdog
// that releases the grant after TIMEOUT_CYCLES stalled cycles and pulses timeout_err.
module xsim_portal_source_arb
   import xsim_arb_pkg::*;
#(
   parameter  int NUM_PORTALS    = 4,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int IW             = $clog2(NUM_PORTALS)
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_PORTALS-1:0][31:0]  portal_ids,
   input  logic [NUM_PORTALS-1:0]        req_valid,
   input  logic [NUM_PORTALS-1:0][31:0]  req_beat,
   output logic [NUM_PORTALS-1:0]        req_ready,
   output logic                          out_en_beat,
   output logic [31:0]                   out_portal,
   output logic [31:0]                   out_beat,
   output logic                          busy,
   output logic [IW-1:0]                 grant_idx,
   output logic                          timeout_err
);

   arb_state_t        r_state;
   logic [IW-1:0]     r_last;
   logic [IW-1:0]     r_grant;
   logic [15:0]       r_rem;
   logic              r_en;
   logic [31:0]       r_portal;
   logic [31:0]       r_beat;

   logic              w_any;
   logic [IW-1:0]     w_pidx;
   logic [IW-1:0]     w_idx;
   logic              w_xfer;
   logic [NUM_PORTALS-1:0] w_ready;
   beat_t             w_beat;
   logic [15:0]       w_len;

   xsim_rr_picker #(.N(NUM_PORTALS), .IW(IW)) u_picker (
      .req  (req_valid),
      .last (r_last),
      .any  (w_any),
      .idx  (w_pidx)
   );

   // Select the transferring requester; nothing is accepted while reset is held.
   always_comb begin
      w_xfer  = 1'b0;
      w_idx   = r_grant;
      w_ready = '0;
      if (!RST) begin
         if (r_state == IDLE) begin
            if (w_any) begin
               w_idx  = w_pidx;
               w_xfer = 1'b1;
            end
         end else if (req_valid[r_grant]) begin
            w_xfer = 1'b1;
         end
      end
      if (w_xfer) w_ready[w_idx] = 1'b1;
      w_beat = req_beat[w_idx];
      w_len  = hdr_len(w_beat);
   end

   assign req_ready   = w_ready;
   assign out_en_beat = r_en;
   assign out_portal  = r_portal;
   assign out_beat    = r_beat;
   assign busy        = (r_state == BODY);
   assign grant_idx   = r_grant;

`ifdef XSIM_ARB_WATCHDOG_EN
   logic [31:0] r_stall;
   logic        r_to;
   assign timeout_err = r_to;
`else
   assign timeout_err = 1'b0;
`endif

   // Arbitration state, beat counter and registered source-channel outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_last   <= IW'(NUM_PORTALS - 1);
         r_grant  <= '0;
         r_rem    <= '0;
         r_en     <= 1'b0;
         r_portal <= '0;
         r_beat   <= '0;
`ifdef XSIM_ARB_WATCHDOG_EN
         r_stall  <= '0;
         r_to     <= 1'b0;
`endif
      end else begin
         r_en <= w_xfer;
         if (w_xfer) begin
            r_beat   <= w_beat;
            r_portal <= portal_ids[w_idx];
         end
`ifdef XSIM_ARB_WATCHDOG_EN
         r_to <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_grant <= w_idx;
                  if (w_len <= 16'd1) begin
                     r_last <= w_idx;
                  end else begin
                     r_state <= BODY;
                     r_rem   <= w_len - 16'd1;
                  end
`ifdef XSIM_ARB_WATCHDOG_EN
                  r_stall <= '0;
`endif
               end
            end
            BODY: begin
               if (w_xfer) begin
`ifdef XSIM_ARB_WATCHDOG_EN
                  r_stall <= '0;
`endif
                  if (r_rem == 16'd1) begin
                     r_state <= IDLE;
                     r_last  <= r_grant;
                  end else begin
                     r_rem <= r_rem - 16'd1;
                  end
               end
`ifdef XSIM_ARB_WATCHDOG_EN
               else if (r_stall == 32'(TIMEOUT_CYCLES - 1)) begin
                  // Give up on the stalled message; its leftovers will be seen as headers.
                  r_to    <= 1'b1;
                  r_state <= IDLE;
                  r_last  <= r_grant;
                  r_stall <= '0;
               end else begin
                  r_stall <= r_stall + 32'd1;
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xsim_portal_source_arb.sv
// Randomized + directed bench for xsim_portal_source_arb with a message-level reference model.
module tb_xsim_portal_source_arb;

   localparam int NP = 4;
`ifdef XSIM_ARB_WATCHDOG_EN
   localparam int TO = 8;
`else
   localparam int TO = 1024;
`endif

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [NP-1:0][31:0]  portal_ids;
   logic [NP-1:0]        req_valid;
   logic [NP-1:0][31:0]  req_beat;
   logic [NP-1:0]        req_ready;
   logic                 out_en_beat;
   logic [31:0]          out_portal;
   logic [31:0]          out_beat;
   logic                 busy;
   logic [1:0]           grant_idx;
   logic                 timeout_err;

   xsim_portal_source_arb #(.NUM_PORTALS(NP), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RST(RST), .portal_ids(portal_ids),
      .req_valid(req_valid), .req_beat(req_beat), .req_ready(req_ready),
      .out_en_beat(out_en_beat), .out_portal(out_portal), .out_beat(out_beat),
      .busy(busy), .grant_idx(grant_idx), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;

   // Pending beats per requester, in stream order
   logic [31:0] q [NP][$];

   // Reference model state: message in flight (-1 = none), words left, last winner, stall count
   int m_cur, m_left, m_last, m_stall;
   logic        e_en, e_to;
   logic [31:0] e_beat, e_portal;
   logic [NP-1:0] obs_ready;
   int          n_to_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pid(input int r);
      return 32'hA000_0000 + 32'(r * 17);
   endfunction

   task automatic push_msg(input int r, input int len);
      logic [15:0] tag;
      tag = 16'($urandom);
      q[r].push_back({tag, 16'(len)});
      for (int i = 1; i < len; i++) q[r].push_back($urandom);
   endtask

   // One clock: present queue heads, predict ready from the arbitration rules, check outputs after the edge.
   task automatic step(input logic [NP-1:0] allow);
      logic [NP-1:0] v, er;
      logic [31:0]   b;
      int            w, len, c;
      @(negedge CLK);
      v = '0;
      for (int r = 0; r < NP; r++) begin
         if (allow[r] && q[r].size() > 0) begin
            v[r] = 1'b1;
            req_beat[r] = q[r][0];
         end else begin
            req_beat[r] = $urandom;
         end
      end
      req_valid = v;
      #1;
      er = '0; w = -1; e_to = 1'b0;
      if (m_cur < 0) begin
         for (int k = 1; k <= NP; k++) begin
            c = (m_last + k) % NP;
            if (w < 0 && v[c]) w = c;
         end
         if (w >= 0) begin
            b = q[w][0];
            len = int'(b[15:0]);
            if (len == 0) len = 1;
            if (len <= 1) m_last = w;
            else begin m_cur = w; m_left = len - 1; m_stall = 0; end
         end
      end else if (v[m_cur]) begin
         w = m_cur;
         m_stall = 0;
         m_left--;
         if (m_left == 0) begin m_last = m_cur; m_cur = -1; end
      end else begin
`ifdef XSIM_ARB_WATCHDOG_EN
         m_stall++;
         if (m_stall == TO) begin
            e_to = 1'b1; m_last = m_cur; m_cur = -1; m_stall = 0;
         end
`endif
      end
      if (w >= 0) begin
         er[w] = 1'b1;
         e_en = 1'b1;
         e_beat = q[w][0];
         e_portal = pid(w);
         void'(q[w].pop_front());
      end else begin
         e_en = 1'b0;
      end
      obs_ready = req_ready;
      chk("req_ready", 32'(req_ready), 32'(er));
      @(posedge CLK);
      #1;
      chk("out_en_beat", 32'(out_en_beat), 32'(e_en));
      chk("out_beat", out_beat, e_beat);
      chk("out_portal", out_portal, e_portal);
      chk("busy", 32'(busy), 32'(m_cur >= 0));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
      if (timeout_err) n_to_seen++;
      if (m_cur >= 0) chk("grant_idx", 32'(grant_idx), 32'(m_cur));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      req_valid = '0;
      @(posedge CLK);
      #1;
      chk("rst_en", 32'(out_en_beat), 32'd0);
      chk("rst_beat", out_beat, 32'd0);
      chk("rst_portal", out_portal, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gidx", 32'(grant_idx), 32'd0);
      chk("rst_to", 32'(timeout_err), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      m_cur = -1; m_left = 0; m_last = NP - 1; m_stall = 0;
      e_en = 1'b0; e_beat = '0; e_portal = '0; e_to = 1'b0;
      for (int r = 0; r < NP; r++) q[r].delete();
   endtask

   function automatic bit pending(input logic [NP-1:0] allow);
      bit p = 0;
      for (int r = 0; r < NP; r++) if (allow[r] && q[r].size() > 0) p = 1;
      return p;
   endfunction

   task automatic drain(input logic [NP-1:0] allow, input int maxc);
      int n = 0;
      while (pending(allow) && n < maxc) begin
         step(allow);
         n++;
      end
      if (pending(allow)) chk("drain_bound", 32'd1, 32'd0);
      // Let any message left in BODY by queue emptiness show up as a stall, not a hang
      step('0);
   endtask

   initial begin
      RST = 1'b1;
      req_valid = '0;
      req_beat = '0;
      n_to_seen = 0;
      for (int r = 0; r < NP; r++) portal_ids[r] = pid(r);
      do_reset();

      // Single portal, lengths 1,2,3 back to back
      push_msg(0, 1); push_msg(0, 2); push_msg(0, 3);
      drain(4'b0001, 20);

      // All four requesters, len-2 messages, order 0,1,2,3,0
      do_reset();
      for (int r = 0; r < NP; r++) push_msg(r, 2);
      push_msg(0, 2);
      drain(4'b1111, 30);

      // Portal 1 len 5 stalls 3 cycles after beat 2; portal 2 must wait
      do_reset();
      push_msg(1, 5); push_msg(2, 1); push_msg(2, 2);
      step(4'b0010); step(4'b0010);
      repeat (3) step(4'b0100);
      drain(4'b0110, 30);

      // Zero-length header is a single beat
      do_reset();
      q[0].push_back(32'h0001_0000);
      push_msg(1, 1); push_msg(2, 2);
      drain(4'b1111, 20);

      // Reset mid-message, requester 0 first after release
      do_reset();
      push_msg(0, 4); push_msg(1, 1);
      step(4'b0001); step(4'b0001);
      do_reset();
      for (int r = 0; r < NP; r++) push_msg(r, 1);
      step(4'b1111);
      chk("rst_first_grant", 32'(obs_ready), 32'h1);
      drain(4'b1111, 20);

`ifdef XSIM_ARB_WATCHDOG_EN
      // Granted requester stalls TO cycles -> one pulse, next requester served
      do_reset();
      n_to_seen = 0;
      push_msg(3, 3); push_msg(0, 1);
      step(4'b1000);
      repeat (TO) step(4'b0001);
      step(4'b0001);
      chk("to_pulses", 32'(n_to_seen), 32'd1);
      chk("to_next_grant", 32'(obs_ready), 32'h1);
      q[3].delete();
      drain(4'b0001, 10);
`endif

      // Randomized traffic with random valid gaps
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [NP-1:0] al;
         int tot;
         tot = 0;
         for (int r = 0; r < NP; r++) tot += q[r].size();
         if (tot < 12 && $urandom_range(0, 1) == 1)
            push_msg(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 6)));
         for (int r = 0; r < NP; r++) al[r] = ($urandom_range(0, 3) != 0);
         step(al);
      end
      drain(4'b1111, 400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
